// File: rtl/rt_mem_port_arb.sv
// rt_mem_port_arb: funnels NUM_REQ ray-tracing requesters onto a single RT
// port of mem_main. Requests are serialized through IDLE -> ISSUE (-> WAIT),
// with one read outstanding at a time and the response routed back to the
// owner.
//
// Timeout: the WAIT counter is 0 in the first WAIT cycle. A read is aborted
// (rsp_err = 1, rsp_rdata = 0) in the WAIT cycle whose counter equals
// RD_TIMEOUT if mem_rd_rdy is still low there. A mem_rd_rdy in that same
// cycle still delivers real data.
//
// Build option: define RT_MEM_ARB_RR_EN for round-robin arbitration starting
// at rr_ptr. When it is left undefined, arbitration is fixed priority (the
// lowest index wins) and no rr_ptr state is built.
module rt_mem_port_arb #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 128,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_grant,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        mem_re,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_rd_rdy,
  output logic                        busy
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [OW-1:0]       r_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [CW-1:0]       r_cnt;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic [OW-1:0]       w_win;
  logic                w_timeout;

  function automatic logic [NUM_REQ-1:0] f_onehot(input logic [OW-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

`ifdef RT_MEM_ARB_RR_EN
  logic [OW-1:0] r_rr_ptr;

  // First requester found when scanning upward from start, wrapping at NUM_REQ.
  function automatic logic [OW-1:0] f_rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [OW-1:0] start);
    logic [OW-1:0] pick;
    logic          hit;
    int            idx;
    pick = start;
    hit  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!hit && v[idx]) begin
        pick = OW'(idx);
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

  // Winner of the current arbitration round.
  always_comb begin
    w_win = f_rr_pick(req_valid, r_rr_ptr);
  end

  // Search start moves one past the owner each time a grant is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (r_state == S_ISSUE) begin
      r_rr_ptr <= (r_owner == OW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
    end
  end
`else
  // Lowest-index requester wins.
  function automatic logic [OW-1:0] f_fixed_pick(input logic [NUM_REQ-1:0] v);
    logic [OW-1:0] pick;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (v[k]) pick = OW'(k);
    end
    return pick;
  endfunction

  // Winner of the current arbitration round.
  always_comb begin
    w_win = f_fixed_pick(req_valid);
  end
`endif

  assign w_timeout = (r_cnt == CW'(RD_TIMEOUT));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; a ready in the timeout cycle still counts as a hit.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (|req_valid) w_next = S_ISSUE;
      S_ISSUE: w_next = r_we ? S_IDLE : S_WAIT;
      S_WAIT:  if (mem_rd_rdy || w_timeout) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes and status decoded only from registered state.
  always_comb begin
    req_grant = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    busy      = (r_state != S_IDLE);
    if (r_state == S_ISSUE) begin
      req_grant = f_onehot(r_owner);
      mem_re    = ~r_we;
      mem_we    = r_we;
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // Request latch, WAIT counter and registered read response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_owner <= w_win;
            r_we    <= req_we[w_win];
            r_addr  <= req_addr[int'(w_win)*ADDR_W +: ADDR_W];
            r_wdata <= req_wdata[int'(w_win)*DATA_W +: DATA_W];
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          if (mem_rd_rdy) begin
            r_rsp_valid <= f_onehot(r_owner);
            r_rsp_rdata <= mem_rdata;
            r_rsp_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_valid <= f_onehot(r_owner);
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rt_mem_port_arb.sv
// Randomized bench for rt_mem_port_arb against a transaction-timestamp model.
module tb_rt_mem_port_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int TO = 12;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_grant, rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err, mem_re, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic            mem_rd_rdy, busy;

  always #5 clk = ~clk;

  rt_mem_port_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rd_rdy(mem_rd_rdy), .busy(busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
  endtask

  // requester agents
  bit            a_v  [N];
  bit            a_we [N];
  logic [AW-1:0] a_addr [N];
  logic [DW-1:0] a_wd [N];
  bit            agents_en = 1'b0;

  // transaction model: one transaction described by its timestamps
  int            cyc = 0;
  bit            t_act = 1'b0, t_we, t_dec, t_err;
  int            t_own, t_start, t_rsp, m_rr = 0;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wd, t_data;

  // memory behaviour
  int            mem_rdy_at = -1;
  logic [DW-1:0] mem_val;
  int            lat_force = 0;
  bit            mem_never = 1'b0, spur_en = 1'b0, force_rdy = 1'b0;

  function automatic logic [DW-1:0] rnd_w();
    logic [DW-1:0] v;
    for (int j = 0; j < DW/32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit m_idle(input int k);
    if (!t_act) return 1'b1;
    if (t_we)   return k >= t_start + 1;
    return t_dec && (k >= t_rsp);
  endfunction

  task automatic new_req(input int i);
    a_v[i]    = 1'b1;
    a_we[i]   = 1'($urandom_range(0, 1));
    a_addr[i] = $urandom;
    a_wd[i]   = rnd_w();
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]             = a_v[i];
      req_we[i]                = a_we[i];
      req_addr[i*AW +: AW]     = a_addr[i];
      req_wdata[i*DW +: DW]    = a_wd[i];
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_grant"}, req_grant, '0);
    chk({pfx, "_rspv"},  rsp_valid, '0);
    chk({pfx, "_rdata"}, rsp_rdata, '0);
    chk({pfx, "_err"},   rsp_err,   '0);
    chk({pfx, "_re"},    mem_re,    '0);
    chk({pfx, "_we"},    mem_we,    '0);
    chk({pfx, "_addr"},  mem_addr,  '0);
    chk({pfx, "_wdata"}, mem_wdata, '0);
    chk({pfx, "_busy"},  busy,      '0);
  endtask

  // Called at a falling edge: check cycle cyc, drive inputs for the next rising edge.
  task automatic do_cycle();
    logic [N-1:0]  eg, ev;
    bit            strobe, rsp, in_wait, rdy;
    logic [DW-1:0] rd;
    int            lat, r, pick, idx;
    strobe = t_act && (cyc == t_start);
    rsp    = t_act && !t_we && t_dec && (cyc == t_rsp);
    eg = '0;
    ev = '0;
    if (strobe) eg[t_own] = 1'b1;
    if (rsp)    ev[t_own] = 1'b1;
    chk("grant",     req_grant, eg);
    chk("rsp_valid", rsp_valid, ev);
    chk("mem_re",    mem_re, strobe && !t_we);
    chk("mem_we",    mem_we, strobe && t_we);
    chk("busy",      busy, t_act && !m_idle(cyc));
    if (strobe) begin
      chk("mem_addr", mem_addr, t_addr);
      if (t_we) chk("mem_wdata", mem_wdata, t_wd);
    end
    if (rsp) begin
      chk("rsp_rdata", rsp_rdata, t_data);
      chk("rsp_err",   rsp_err, t_err);
    end
    // requesters drop or replace a request at the edge ending its grant cycle
    for (int i = 0; i < N; i++) begin
      if (eg[i]) begin
        a_v[i] = 1'b0;
        if (agents_en && $urandom_range(0, 1) == 1) new_req(i);
      end else if (!a_v[i] && agents_en && $urandom_range(0, 5) == 0) begin
        new_req(i);
      end
    end
    // memory picks its answer time when it sees the read strobe
    if (strobe && !t_we) begin
      mem_val = rnd_w();
      if (mem_never) lat = -1;
      else if (lat_force > 0) begin
        lat       = lat_force;
        mem_val   = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0BADF00D};
        lat_force = 0;
      end else begin
        r = $urandom_range(0, 9);
        case (r)
          0:       lat = TO + 1;
          1:       lat = -1;
          2:       lat = TO + 2;
          default: lat = $urandom_range(1, 4);
        endcase
      end
      mem_rdy_at = (lat < 0) ? -1 : cyc + lat;
    end
    in_wait = t_act && !t_we && !t_dec && (cyc >= t_start + 1);
    rdy = (cyc == mem_rdy_at) || force_rdy ||
          (!in_wait && spur_en && $urandom_range(0, 7) == 0);
    force_rdy = 1'b0;
    rd = (cyc == mem_rdy_at) ? mem_val : rnd_w();
    mem_rd_rdy = rdy;
    mem_rdata  = rd;
    // model: what the coming rising edge does
    if (in_wait) begin
      if (rdy) begin
        t_dec = 1'b1; t_err = 1'b0; t_data = rd; t_rsp = cyc + 1;
      end else if (cyc == t_start + 1 + TO) begin
        t_dec = 1'b1; t_err = 1'b1; t_data = '0; t_rsp = cyc + 1;
      end
    end
    if (m_idle(cyc)) begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
`ifdef RT_MEM_ARB_RR_EN
        idx = (m_rr + k) % N;
`else
        idx = k;
`endif
        if (pick < 0 && a_v[idx]) pick = idx;
      end
      if (pick >= 0) begin
        t_act = 1'b1; t_own = pick; t_we = a_we[pick];
        t_addr = a_addr[pick]; t_wd = a_wd[pick];
        t_start = cyc + 1; t_dec = 1'b0;
        m_rr = (pick + 1) % N;
      end
    end
    drive_reqs();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int guard;
    bit pend;
    guard = 0;
    pend  = 1'b1;
    while (pend && guard < 2000) begin
      pend = !m_idle(cyc);
      for (int i = 0; i < N; i++) if (a_v[i]) pend = 1'b1;
      if (pend) begin
        do_cycle();
        guard++;
      end
    end
    chk("drain_timeout", pend, 1'b0);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < N; i++) begin
      a_v[i] = 1'b0; a_we[i] = 1'b0; a_addr[i] = '0; a_wd[i] = '0;
    end
    drive_reqs();
    mem_rd_rdy = 1'b0;
    mem_rdata  = '0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // single write from requester 2
    a_v[2] = 1'b1; a_we[2] = 1'b1; a_addr[2] = 32'h0020_0000; a_wd[2] = 128'h2;
    repeat (5) do_cycle();
    // single read from requester 1, memory answers in the 3rd WAIT cycle
    a_v[1] = 1'b1; a_we[1] = 1'b0; a_addr[1] = 32'h0010_0000; a_wd[1] = '0;
    lat_force = 3;
    repeat (8) do_cycle();
    // all four read at once
    for (int i = 0; i < N; i++) begin
      a_v[i] = 1'b1; a_we[i] = 1'b0; a_addr[i] = 32'h1000 * (i + 1);
    end
    drain();

    // randomized traffic with spurious ready pulses
    agents_en = 1'b1;
    spur_en   = 1'b1;
    repeat (1200) do_cycle();
    agents_en = 1'b0;
    drain();

    // reset while a read sits in WAIT, then a late ready must be dropped
    spur_en   = 1'b0;
    mem_never = 1'b1;
    a_v[2] = 1'b1; a_we[2] = 1'b0; a_addr[2] = 32'h0300_0000;
    guard = 0;
    while (!(t_act && !t_we && cyc >= t_start + 2) && guard < 20) begin
      do_cycle();
      guard++;
    end
    chk("reach_wait", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    t_act = 1'b0; m_rr = 0; mem_rdy_at = -1;
    for (int i = 0; i < N; i++) a_v[i] = 1'b0;
    drive_reqs();
    mem_rd_rdy = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n     = 1'b1;
    mem_never = 1'b0;
    force_rdy = 1'b1;
    repeat (6) do_cycle();

    // traffic again after reset
    agents_en = 1'b1;
    spur_en   = 1'b1;
    repeat (600) do_cycle();
    agents_en = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rt_mem_port_arb.md
Name: rt_mem_port_arb

Overview:
- Arbitrates NUM_REQ ray-tracing core requesters onto one RT port of mem_main: re_RT/we_RT/addr_RT/data_RT_in out, data_RT_out/rd_rdy_RT back.
- Sits directly upstream of mem_main. One instance per RT port, so 4 instances feed mem_main.
- Serializes requests, tracks one outstanding read, and routes the read response back to the owning requester, with a read timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 128, data width.
- RD_TIMEOUT, 255, maximum WAIT cycles before a read is aborted (1..1023).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_grant  out  NUM_REQ  one-cycle accept pulse, one-hot.
- rsp_valid  out  NUM_REQ  one-cycle read-response pulse, one-hot.
- rsp_rdata  out  DATA_W  shared read data, valid with rsp_valid.
- rsp_err  out  1  read timed out; valid with rsp_valid.
- mem_re  out  1  to mem_main re_RT.
- mem_we  out  1  to mem_main we_RT.
- mem_addr  out  ADDR_W  to mem_main addr_RT.
- mem_wdata  out  DATA_W  to mem_main data_RT_in.
- mem_rdata  in  DATA_W  from mem_main data_RT_out.
- mem_rd_rdy  in  1  from mem_main rd_rdy_RT.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE; all outputs 0; owner = 0; rr_ptr = 0; timeout counter = 0.
  - Reset mid-operation drops any pending read; no rsp_valid is issued for it.
- Output timing: all outputs are registered or decoded purely from registered state. No combinational path from any input to any output.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid is high at edge T, the winner is latched: owner, we, addr, wdata. Next state is ISSUE.
  - If no req_valid is high, remain in IDLE.
- ISSUE (one cycle, T+1):
  - req_grant[owner] = 1.
  - mem_re = ~we, mem_we = we; mem_addr/mem_wdata = latched values.
  - Write: next state IDLE; there is no response.
  - Read: next state WAIT; counter cleared.
  - mem_rd_rdy is ignored in this cycle; mem_main has at least 1 cycle of read latency.
- WAIT:
  - mem_re/mem_we = 0; counter increments each cycle.
  - If mem_rd_rdy is high: capture mem_rdata, then assert rsp_valid[owner] with rsp_rdata and rsp_err = 0 in the next cycle (in IDLE). Next state IDLE.
  - If counter == RD_TIMEOUT without mem_rd_rdy: rsp_valid[owner] = 1, rsp_rdata = 0, rsp_err = 1. Next state IDLE.
  - If mem_rd_rdy and timeout coincide, mem_rd_rdy wins.
- Spurious mem_rd_rdy in IDLE or ISSUE is ignored.
- Throughput:
  - Write: 2 cycles per request (arbitrate edge + ISSUE). Back-to-back writes give a grant every 2 cycles.
  - Read: minimum 4 cycles from request to rsp_valid, with rd_rdy arriving in the first WAIT cycle.
- Requester contract:
  - Hold req_valid/req_we/req_addr/req_wdata stable until req_grant is seen.
  - Deassert req_valid or present the next request at the edge ending the grant cycle.
  - The arbiter samples fields only at the arbitration edge.
- Arbitration (see Optional Feature). rr_ptr is updated to owner+1 (mod NUM_REQ) on every grant.
- Requester requests in the rsp_valid cycle: it may be arbitrated at the same edge, with no stall.

Optional Feature:
- Macro: RT_MEM_ARB_RR_EN.
- Defined: round-robin arbitration. The search starts at rr_ptr and wraps; the winner is the first req_valid found.
- Undefined: fixed priority, lowest index wins. rr_ptr logic is not built.

Test Plan:
- Single write: req_valid[2] = 1, we = 1, addr = 0x00200000, wdata = 0x...0002 → req_grant[2] and mem_we = 1 with the same addr/data exactly one cycle after the arbitration edge; busy returns to 0 the next cycle; no rsp_valid.
- Single read, 3-cycle memory: req[1] read addr = 0x00100000, mem_rd_rdy pulses in the 3rd WAIT cycle with rdata = 0xDEADBEEF_... → rsp_valid[1] one cycle later, rsp_rdata = 0xDEADBEEF_..., rsp_err = 0.
- Contention: all 4 requesters issue reads simultaneously, with memory answering after 2 cycles.
  - RR_EN defined: grants in order 0, 1, 2, 3; a re-asserted req0 is served after 3.
  - RR_EN undefined, req0 held continuously: req1–3 are never granted while req0 requests.
- Timeout: read from req[3], mem_rd_rdy never asserted → rsp_valid[3] with rsp_err = 1 and rsp_rdata = 0 after RD_TIMEOUT WAIT cycles; the next request is then served normally.
- Reset and spurious ready:
  - Assert rst_n = 0 during WAIT → all outputs 0 immediately.
  - After release, a late mem_rd_rdy pulse produces no rsp_valid, and a spurious mem_rd_rdy in IDLE is ignored.
- Boundary: mem_rd_rdy and timeout in the same cycle (counter == RD_TIMEOUT) → rsp_err = 0 with the real data. A requester asserting in the rsp_valid cycle is granted at that edge.
